// File: rtl/mesh_node_ctrl.sv
// X-by-Y mesh node controller: populated mask, staggered boot, gated flit paths, drain.
// Optional per-node flit counters are enabled by defining NODE_FLIT_COUNT_EN.
//
// state | meaning
// IDLE  | all cores held in reset, mask loadable, waiting for start
// BOOT  | walking nodes in index order, releasing populated ones every BOOT_GAP cycles
// RUN   | steady state, released nodes exchange flits with the noc
// DRAIN | noc marked unavailable, waiting for QUIET idle cycles before resetting cores
module mesh_node_ctrl #(
   parameter int X        = 3,
   parameter int Y        = 3,
   parameter int FLIT_W   = 32,
   parameter int BOOT_GAP = 4,
   parameter int QUIET    = 8,
   localparam int N       = X * Y
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_mask_valid,
   input  logic [N-1:0]        cfg_mask,
   input  logic                start,
   input  logic                halt,
   input  logic [N*FLIT_W-1:0] core_flit_in,
   output logic [N*FLIT_W-1:0] core_flit_out,
   input  logic [N*FLIT_W-1:0] noc_flit_in,
   output logic [N*FLIT_W-1:0] to_core_flit,
   output logic [N-1:0]        core_rst_n,
   output logic [N-1:0]        core_avail,
   output logic [1:0]          state,
   output logic                busy
`ifdef NODE_FLIT_COUNT_EN
   ,
   output logic [N*16-1:0]     flit_count
`endif
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int GAP_W = $clog2(BOOT_GAP + 1);
   localparam int QW    = $clog2(QUIET + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BOOT  = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [N-1:0]        mask_q, mask_d;
   logic [N-1:0]        rst_n_q, rst_n_d;
   logic [N-1:0]        avail_q, avail_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [QW-1:0]       quiet_q, quiet_d;
   logic [N*FLIT_W-1:0] c2n_q, c2n_d;
   logic [N*FLIT_W-1:0] n2c_q, n2c_d;
   logic                noc_any;
   logic                idx_last;

   always_comb begin
      noc_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (noc_flit_in[k*FLIT_W +: FLIT_W] != '0) noc_any = 1'b1;
      end
   end

   assign idx_last = (idx_q == IDX_W'(N - 1));

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      rst_n_d = rst_n_q;
      avail_d = avail_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      quiet_d = quiet_q;
      case (state_q)
         S_IDLE: begin
            if (cfg_mask_valid) mask_d = cfg_mask;
            if (start) begin
               state_d = S_BOOT;
               idx_d   = '0;
               gap_d   = '0;
            end
         end
         S_BOOT: begin
            // halt preempts any release due on the same edge
            if (halt) begin
               state_d = S_DRAIN;
               avail_d = '0;
               quiet_d = '0;
            end else if (!mask_q[idx_q]) begin
               idx_d = idx_q + 1'b1;
               if (idx_last) state_d = S_RUN;
            end else if (gap_q == GAP_W'(BOOT_GAP - 1)) begin
               rst_n_d[idx_q] = 1'b1;
               avail_d[idx_q] = 1'b1;
               gap_d          = '0;
               idx_d          = idx_q + 1'b1;
               if (idx_last) state_d = S_RUN;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_RUN: begin
            if (halt) begin
               state_d = S_DRAIN;
               avail_d = '0;
               quiet_d = '0;
            end
         end
         S_DRAIN: begin
            if (noc_any) begin
               quiet_d = '0;
            end else if (quiet_q == QW'(QUIET - 1)) begin
               quiet_d = '0;
               rst_n_d = '0;
               state_d = S_IDLE;
            end else begin
               quiet_d = quiet_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // gating uses the registered reset/state, so each path is exactly one stage
   always_comb begin
      c2n_d = '0;
      n2c_d = '0;
      for (int k = 0; k < N; k++) begin
         if (rst_n_q[k] && state_q != S_DRAIN)
            c2n_d[k*FLIT_W +: FLIT_W] = core_flit_in[k*FLIT_W +: FLIT_W];
         if (rst_n_q[k])
            n2c_d[k*FLIT_W +: FLIT_W] = noc_flit_in[k*FLIT_W +: FLIT_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mask_q  <= '1;
         rst_n_q <= '0;
         avail_q <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         quiet_q <= '0;
         c2n_q   <= '0;
         n2c_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         rst_n_q <= rst_n_d;
         avail_q <= avail_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         quiet_q <= quiet_d;
         c2n_q   <= c2n_d;
         n2c_q   <= n2c_d;
      end
   end

   assign core_flit_out = c2n_q;
   assign to_core_flit  = n2c_q;
   assign core_rst_n    = rst_n_q;
   assign core_avail    = avail_q;
   assign state         = state_q;
   assign busy          = (state_q != S_IDLE);

`ifdef NODE_FLIT_COUNT_EN
   logic [N*16-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < N; k++) begin
         if (state_q == S_IDLE && start)
            cnt_d[k*16 +: 16] = '0;
         else if (c2n_d[k*FLIT_W +: FLIT_W] != '0 && cnt_q[k*16 +: 16] != 16'hFFFF)
            cnt_d[k*16 +: 16] = cnt_q[k*16 +: 16] + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign flit_count = cnt_q;
`endif

endmodule

// File: tb/tb_mesh_node_ctrl.sv
// Randomised bench for mesh_node_ctrl against a schedule-based reference model.
// Build with +define+NODE_FLIT_COUNT_EN to also cover the flit counters.
module tb_mesh_node_ctrl;
   localparam int X = 3, Y = 3, N = 9, FW = 32, BG = 4, QT = 8;

   logic              clk = 1'b0;
   logic              rst, cfg_mask_valid, start, halt;
   logic [N-1:0]      cfg_mask;
   logic [N*FW-1:0]   core_flit_in, core_flit_out, noc_flit_in, to_core_flit;
   logic [N-1:0]      core_rst_n, core_avail;
   logic [1:0]        state;
   logic              busy;
`ifdef NODE_FLIT_COUNT_EN
   logic [N*16-1:0]   flit_count;
`endif

   always #5 clk = ~clk;

   mesh_node_ctrl #(.X(X), .Y(Y), .FLIT_W(FW), .BOOT_GAP(BG), .QUIET(QT)) dut (
      .clk(clk), .rst(rst), .cfg_mask_valid(cfg_mask_valid), .cfg_mask(cfg_mask),
      .start(start), .halt(halt), .core_flit_in(core_flit_in), .core_flit_out(core_flit_out),
      .noc_flit_in(noc_flit_in), .to_core_flit(to_core_flit), .core_rst_n(core_rst_n),
      .core_avail(core_avail), .state(state), .busy(busy)
`ifdef NODE_FLIT_COUNT_EN
      , .flit_count(flit_count)
`endif
   );

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [N*FW-1:0] act, input logic [N*FW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, act, exp);
      end
   endtask

   // reference model: release times come from a precomputed schedule
   int            m_state, m_cyc, m_total, m_quiet;
   int            m_rel[N];
   int            m_cnt[N];
   logic [N-1:0]  m_mask, m_rst_n, m_avail;
   logic [N*FW-1:0] m_c2n, m_n2c;

   function automatic void model_reset();
      m_state = 0; m_mask = '1; m_rst_n = '0; m_avail = '0;
      m_c2n = '0; m_n2c = '0; m_quiet = 0; m_cyc = 0; m_total = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
   endfunction

   function automatic void model_edge();
      for (int k = 0; k < N; k++) begin
         m_c2n[k*FW +: FW] = (m_rst_n[k] && m_state != 3) ? core_flit_in[k*FW +: FW] : '0;
         m_n2c[k*FW +: FW] = m_rst_n[k] ? noc_flit_in[k*FW +: FW] : '0;
         if (m_state == 0 && start) m_cnt[k] = 0;
         else if (m_c2n[k*FW +: FW] != '0 && m_cnt[k] < 65535) m_cnt[k]++;
      end
      case (m_state)
         0: begin
            if (cfg_mask_valid) m_mask = cfg_mask;
            if (start) begin
               m_state = 1; m_cyc = 0; m_total = 0;
               for (int k = 0; k < N; k++) begin
                  m_total += m_mask[k] ? BG : 1;
                  m_rel[k] = m_total;
               end
            end
         end
         1: begin
            if (halt) begin
               m_state = 3; m_avail = '0; m_quiet = 0;
            end else begin
               m_cyc++;
               for (int k = 0; k < N; k++)
                  if (m_mask[k] && m_cyc == m_rel[k]) begin
                     m_rst_n[k] = 1'b1; m_avail[k] = 1'b1;
                  end
               if (m_cyc == m_total) m_state = 2;
            end
         end
         2: if (halt) begin m_state = 3; m_avail = '0; m_quiet = 0; end
         default: begin
            if (noc_flit_in != '0) m_quiet = 0;
            else begin
               m_quiet++;
               if (m_quiet == QT) begin m_state = 0; m_rst_n = '0; m_quiet = 0; end
            end
         end
      endcase
   endfunction

   task automatic compare_all();
      chk("state", N*FW'(state), N*FW'(m_state[1:0]));
      chk("core_rst_n", N*FW'(core_rst_n), N*FW'(m_rst_n));
      chk("core_avail", N*FW'(core_avail), N*FW'(m_avail));
      chk("busy", N*FW'(busy), N*FW'(m_state != 0));
      chk("core_flit_out", core_flit_out, m_c2n);
      chk("to_core_flit", to_core_flit, m_n2c);
`ifdef NODE_FLIT_COUNT_EN
      for (int k = 0; k < N; k++)
         chk("flit_count", N*FW'(flit_count[k*16 +: 16]), N*FW'(m_cnt[k]));
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   function automatic logic [N*FW-1:0] rand_flits(input int zero_pct);
      logic [N*FW-1:0] v;
      v = '0;
      if ($urandom_range(99) < zero_pct) return v;
      for (int k = 0; k < N; k++)
         v[k*FW +: FW] = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
      return v;
   endfunction

   task automatic drain_to_idle();
      halt = 1'b1; noc_flit_in = '0;
      tick();
      halt = 1'b0;
      for (int i = 0; i < QT; i++) tick();
      chk("drain_idle", N*FW'(state), N*FW'(0));
   endtask

   initial begin
      rst = 1'b1; cfg_mask_valid = 1'b0; start = 1'b0; halt = 1'b0;
      cfg_mask = '0; core_flit_in = '0; noc_flit_in = '0;
      model_reset();
      #12;
      compare_all();
      rst = 1'b0;
      tick(); tick();

      // full boot
      cfg_mask_valid = 1'b1; cfg_mask = '1; start = 1'b1;
      tick();
      cfg_mask_valid = 1'b0; start = 1'b0;
      for (int e = 1; e <= 36; e++) begin
         core_flit_in = rand_flits(20); noc_flit_in = rand_flits(20);
         tick();
         if (e == 3)  chk("n0_e3", N*FW'(core_rst_n[0]), N*FW'(0));
         if (e == 4)  chk("n0_e4", N*FW'(core_rst_n[0]), N*FW'(1));
         if (e == 35) chk("boot_e35", N*FW'(state), N*FW'(1));
         if (e == 36) begin
            chk("run_e36", N*FW'(state), N*FW'(2));
            chk("all_rel", N*FW'(core_rst_n), N*FW'(9'h1FF));
         end
      end
      for (int i = 0; i < 8; i++) begin
         core_flit_in = rand_flits(20); noc_flit_in = rand_flits(20);
         start = 1'($urandom_range(1)); cfg_mask_valid = 1'($urandom_range(1));
         cfg_mask = 9'($urandom);
         tick();
      end
      start = 1'b0; cfg_mask_valid = 1'b0;

      // drain with traffic on node 4
      halt = 1'b1; noc_flit_in = '0; noc_flit_in[4*FW +: FW] = 32'hA5;
      core_flit_in = rand_flits(0);
      tick();
      chk("drain_avail", N*FW'(core_avail), N*FW'(0));
      halt = 1'b0;
      tick();
      chk("drain_c2n", core_flit_out, '0);
      chk("drain_n2c4", N*FW'(to_core_flit[4*FW +: FW]), N*FW'(32'hA5));
      tick();
      noc_flit_in = '0;
      for (int i = 0; i < 7; i++) tick();
      chk("drain_q7", N*FW'(state), N*FW'(3));
      tick();
      chk("drain_q8", N*FW'(state), N*FW'(0));
      chk("drain_rst", N*FW'(core_rst_n), N*FW'(0));

      // sparse boot
      core_flit_in = '0;
      cfg_mask_valid = 1'b1; cfg_mask = 9'b000010001;
      tick();
      cfg_mask_valid = 1'b0; cfg_mask = 9'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      for (int e = 1; e <= 15; e++) begin
         noc_flit_in = rand_flits(30);
         tick();
         if (e == 4)  chk("sp_e4", N*FW'(core_rst_n), N*FW'(9'h001));
         if (e == 10) chk("sp_e10", N*FW'(core_rst_n), N*FW'(9'h001));
         if (e == 11) chk("sp_e11", N*FW'(core_rst_n), N*FW'(9'h011));
         if (e == 14) chk("sp_e14", N*FW'(state), N*FW'(1));
         if (e == 15) chk("sp_e15", N*FW'(state), N*FW'(2));
      end
      core_flit_in = '0;
      core_flit_in[0*FW +: FW] = 32'hDEADBEEF;
      core_flit_in[3*FW +: FW] = 32'h1;
      tick();
      chk("gate_n0", N*FW'(core_flit_out[0 +: FW]), N*FW'(32'hDEADBEEF));
      chk("gate_n3", N*FW'(core_flit_out[3*FW +: FW]), N*FW'(0));
      for (int i = 0; i < 2; i++) begin
         core_flit_in[0 +: FW] = $urandom | 32'h1;
         tick();
      end
`ifdef NODE_FLIT_COUNT_EN
      chk("cnt_n0", N*FW'(flit_count[0 +: 16]), N*FW'(3));
`endif
      core_flit_in = '0;
      start = 1'b1; cfg_mask_valid = 1'b1; cfg_mask = '0;
      tick(); tick();
      start = 1'b0; cfg_mask_valid = 1'b0;
      chk("ign_state", N*FW'(state), N*FW'(2));
      chk("ign_rst", N*FW'(core_rst_n), N*FW'(9'h011));
      drain_to_idle();

      // all-zero mask, loaded together with start
      cfg_mask_valid = 1'b1; cfg_mask = '0; start = 1'b1;
      tick();
      cfg_mask_valid = 1'b0; start = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         tick();
         if (e == 8) chk("z_e8", N*FW'(state), N*FW'(1));
         if (e == 9) chk("z_e9", N*FW'(state), N*FW'(2));
      end
      chk("z_rst", N*FW'(core_rst_n), N*FW'(0));
      drain_to_idle();

      // halt with start during boot
      cfg_mask_valid = 1'b1; cfg_mask = '1; start = 1'b1;
      tick();
      cfg_mask_valid = 1'b0; start = 1'b0;
      for (int e = 1; e <= 5; e++) tick();
      halt = 1'b1; start = 1'b1;
      tick();
      chk("hb_state", N*FW'(state), N*FW'(3));
      chk("hb_rst", N*FW'(core_rst_n), N*FW'(9'h001));
      halt = 1'b0; start = 1'b0;
      for (int i = 0; i < QT; i++) tick();

      // random traffic with an async reset in the middle
      for (int i = 0; i < 600; i++) begin
         start          = ($urandom_range(99) < 10);
         halt           = ($urandom_range(99) < 3);
         cfg_mask_valid = ($urandom_range(99) < 10);
         cfg_mask       = 9'($urandom);
         core_flit_in   = rand_flits(20);
         noc_flit_in    = rand_flits(70);
         tick();
         if (i == 300) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            compare_all();
            rst = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
